// File: rtl/multi_comparer_sync.sv
// multi_comparer_sync
//   Parallel header matcher for NMEA-style byte streams. Each byte presented
//   with `load` is compared against K reference headers of L bytes. Completed
//   headers are reported on a registered one-cycle pulse. The result selects
//   which sentence parser consumes the fields that follow.
//
// Ports
//   clock    in   rising-edge system clock
//   reset    in   synchronous, active-high; has priority over restart
//   restart  in   restart every comparison from this cycle (current byte included)
//   load     in   `data` is valid this cycle
//   data     in   B-bit stream byte
//   hit      out  one-cycle pulse: some pattern completed on the previous load
//   hit_vec  out  K-bit set of patterns that completed (0 when hit=0)
//   hit_id   out  lowest set index of hit_vec (0 when hit=0)
//   reject   out  one-cycle pulse: the previous loaded byte advanced no pattern
//   alive    out  K-bit level: patterns still able to match
module multi_comparer_sync #(
  parameter int               B        = 8,
  parameter int               L        = 6,
  parameter int               K        = 4,
  parameter logic [K*L*B-1:0] REFS     = {"$GPZDA", "$GPGGA", "$GPRMC", "$GPGSV"},
  parameter logic [K*L-1:0]   MASK     = '1,
  parameter bit               ANCHORED = 1'b0,
  parameter int               IW       = (K > 1) ? $clog2(K) : 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          restart,
  input  logic          load,
  input  logic [B-1:0]  data,
  output logic          hit,
  output logic [K-1:0]  hit_vec,
  output logic [IW-1:0] hit_id,
  output logic          reject,
  output logic [K-1:0]  alive
);

  localparam int PW = $clog2(L + 1);

  // Byte j of pattern k; pattern 0 sits in the most-significant slot and
  // byte 0 (sent first) is the most-significant byte of its pattern.
  function automatic logic [B-1:0] ref_byte(input int k, input int j);
    return REFS[(K-1-k)*L*B + (L-1-j)*B +: B];
  endfunction

  // 1 = byte j of pattern k must match, 0 = wildcard.
  function automatic logic care_bit(input int k, input int j);
    return MASK[(K-1-k)*L + (L-1-j)];
  endfunction

  logic [PW-1:0] p_q [K];
  logic [PW-1:0] p_d [K];
  logic [K-1:0]  alive_q, alive_d;
  logic [K-1:0]  hit_vec_q, hit_vec_d;
  logic [IW-1:0] hit_id_q, hit_id_d;
  logic          hit_q, hit_d;
  logic          reject_q, reject_d;

  always_comb begin
    logic [PW-1:0] pe;
    logic          ae, m, m0, adv_any;
    adv_any   = 1'b0;
    hit_vec_d = '0;
    alive_d   = alive_q;
    hit_id_d  = '0;
    for (int k = 0; k < K; k++) begin
      // Restart overrides the stored state before the current byte is
      // compared, so the byte arriving with restart is matched at position 0.
      pe = restart ? '0 : p_q[k];
      ae = restart | alive_q[k];
      m  = !care_bit(k, int'(pe)) || (data == ref_byte(k, int'(pe)));
      m0 = !care_bit(k, 0) || (data == ref_byte(k, 0));
      p_d[k]     = pe;
      alive_d[k] = ae;
      if (load && ae) begin
        if (m && (pe == PW'(L - 1))) begin
          hit_vec_d[k] = 1'b1;
          p_d[k]       = '0;
          if (ANCHORED) alive_d[k] = 1'b0;
          adv_any = 1'b1;
        end else if (m) begin
          p_d[k]  = pe + PW'(1);
          adv_any = 1'b1;
        end else if (!ANCHORED) begin
          // Single-byte retry: a mismatching byte may itself start the header.
          // Such a restart at position 1 still counts as progress for reject.
          p_d[k] = m0 ? PW'(1) : '0;
          if (m0) adv_any = 1'b1;
        end else begin
          alive_d[k] = 1'b0;
          p_d[k]     = '0;
        end
      end
    end
    // Descending scan leaves the lowest completing index.
    for (int k = K - 1; k >= 0; k--) begin
      if (hit_vec_d[k]) hit_id_d = IW'(k);
    end
    hit_d    = |hit_vec_d;
    reject_d = load && !adv_any;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < K; k++) p_q[k] <= '0;
      alive_q   <= '1;
      hit_q     <= 1'b0;
      hit_vec_q <= '0;
      hit_id_q  <= '0;
      reject_q  <= 1'b0;
    end else begin
      for (int k = 0; k < K; k++) p_q[k] <= p_d[k];
      alive_q   <= alive_d;
      hit_q     <= hit_d;
      hit_vec_q <= hit_vec_d;
      hit_id_q  <= hit_id_d;
      reject_q  <= reject_d;
    end
  end

  assign hit     = hit_q;
  assign hit_vec = hit_vec_q;
  assign hit_id  = hit_id_q;
  assign reject  = reject_q;
  assign alive   = alive_q;

endmodule

// File: tb/tb_multi_comparer_sync.sv
// Scoreboard bench for multi_comparer_sync. Three instances cover the default
// configuration (u0), ANCHORED=1 (u1) and a two-pattern wildcard setup (u2).
module tb_multi_comparer_sync;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst [3];
  logic       rs  [3];
  logic       ld  [3];
  logic [7:0] dat [3];

  logic       h0, rj0; logic [3:0] v0; logic [1:0] id0; logic [3:0] al0;
  logic       h1, rj1; logic [3:0] v1; logic [1:0] id1; logic [3:0] al1;
  logic       h2, rj2; logic [1:0] v2; logic [0:0] id2; logic [1:0] al2;

  multi_comparer_sync u0 (
    .clock(clk), .reset(rst[0]), .restart(rs[0]), .load(ld[0]), .data(dat[0]),
    .hit(h0), .hit_vec(v0), .hit_id(id0), .reject(rj0), .alive(al0));

  multi_comparer_sync #(.ANCHORED(1'b1)) u1 (
    .clock(clk), .reset(rst[1]), .restart(rs[1]), .load(ld[1]), .data(dat[1]),
    .hit(h1), .hit_vec(v1), .hit_id(id1), .reject(rj1), .alive(al1));

  multi_comparer_sync #(
    .K(2), .REFS({"$GPZDA", "$GP???"}), .MASK(12'b111111_111000)) u2 (
    .clock(clk), .reset(rst[2]), .restart(rs[2]), .load(ld[2]), .data(dat[2]),
    .hit(h2), .hit_vec(v2), .hit_id(id2), .reject(rj2), .alive(al2));

  typedef struct packed {
    logic       h;
    logic [3:0] v;
    logic [1:0] id;
    logic       rj;
    logic [3:0] al;
  } exp_t;

  exp_t q0[$], q1[$], q2[$];
  int   nvec  = 0;
  int   nfail = 0;
  logic pl [3];

  // A response is due in the cycle after an accepted (non-reset) load.
  always @(posedge clk) begin
    for (int u = 0; u < 3; u++) pl[u] <= ld[u] && !rst[u];
  end

  task automatic chk(input int u, input logic h, input logic [3:0] v,
                     input logic [1:0] id, input logic rj, input logic [3:0] al);
    exp_t e, a;
    logic got;
    a   = '{h, v, id, rj, al};
    e   = '0;
    got = 1'b0;
    nvec++;
    if (pl[u]) begin
      case (u)
        0: if (q0.size() > 0) begin e = q0.pop_front(); got = 1'b1; end
        1: if (q1.size() > 0) begin e = q1.pop_front(); got = 1'b1; end
        default: if (q2.size() > 0) begin e = q2.pop_front(); got = 1'b1; end
      endcase
      if (!got) begin
        nfail++;
        $display("FAIL u%0d resp: response with empty scoreboard h=%b rj=%b", u, h, rj);
      end else if (a !== e) begin
        nfail++;
        $display("FAIL u%0d resp @%0t: h/vec/id/rej/alive got %b/%b/%b/%b/%b want %b/%b/%b/%b/%b",
                 u, $time, a.h, a.v, a.id, a.rj, a.al, e.h, e.v, e.id, e.rj, e.al);
      end
    end else if ({h, v, id, rj} !== 8'd0) begin
      nfail++;
      $display("FAIL u%0d idle @%0t: h/vec/id/rej got %b/%b/%b/%b want all 0",
               u, $time, h, v, id, rj);
    end
  endtask

  always @(negedge clk) begin
    chk(0, h0, v0, id0, rj0, al0);
    chk(1, h1, v1, id1, rj1, al1);
    chk(2, h2, {2'b00, v2}, {1'b0, id2}, rj2, {2'b00, al2});
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input int u, input byte b, input logic r,
                      input logic eh, input logic [3:0] ev, input logic [1:0] eid,
                      input logic erj, input logic [3:0] eal);
    exp_t e;
    e = '{eh, ev, eid, erj, eal};
    ld[u] = 1'b1; dat[u] = b; rs[u] = r;
    case (u)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
    @(negedge clk);
    ld[u] = 1'b0; rs[u] = 1'b0;
  endtask

  // Streams a string; only the last byte carries the given hit expectation,
  // no byte is expected to reject. Gaps cycle through 0..gapmax idle cycles.
  task automatic stream(input int u, input string s, input int gapmax,
                        input logic [3:0] al, input logic lh,
                        input logic [3:0] lv, input logic [1:0] lid);
    for (int i = 0; i < s.len(); i++) begin
      if (i == s.len() - 1) send(u, s[i], 1'b0, lh, lv, lid, 1'b0, al);
      else                  send(u, s[i], 1'b0, 1'b0, 4'd0, 2'd0, 1'b0, al);
      if (gapmax > 0) idle(i % (gapmax + 1));
    end
  endtask

  task automatic chk_alive(input string nm, input logic [3:0] act, input logic [3:0] req);
    nvec++;
    if (act !== req) begin
      nfail++;
      $display("FAIL %s: alive got %b want %b", nm, act, req);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    for (int u = 0; u < 3; u++) begin
      rst[u] = 1'b1; rs[u] = 1'b0; ld[u] = 1'b0; dat[u] = 8'h00;
    end
    idle(2);
    for (int u = 0; u < 3; u++) rst[u] = 1'b0;
    chk_alive("u0 reset alive", al0, 4'hF);
    chk_alive("u1 reset alive", al1, 4'hF);
    chk_alive("u2 reset alive", {2'b00, al2}, 4'b0011);

    // Default configuration
    stream(0, "$GPZDA", 0, 4'hF, 1'b1, 4'b0001, 2'd0);
    stream(0, "$GPRMC", 3, 4'hF, 1'b1, 4'b0100, 2'd2);
    idle(2);
    stream(0, "$GP$GPGGA", 0, 4'hF, 1'b1, 4'b0010, 2'd1);
    send(0, "X", 1'b0, 1'b0, 4'd0, 2'd0, 1'b1, 4'hF);
    // restart together with the final byte: matched from position 0
    stream(0, "$GPZD", 0, 4'hF, 1'b0, 4'd0, 2'd0);
    send(0, "A", 1'b1, 1'b0, 4'd0, 2'd0, 1'b1, 4'hF);
    // restart with the first byte of a fresh header: no byte lost
    stream(0, "$GP", 0, 4'hF, 1'b0, 4'd0, 2'd0);
    send(0, "$", 1'b1, 1'b0, 4'd0, 2'd0, 1'b0, 4'hF);
    stream(0, "GPZDA", 0, 4'hF, 1'b1, 4'b0001, 2'd0);
    stream(0, "$GPGSV", 0, 4'hF, 1'b1, 4'b1000, 2'd3);
    // reset mid-stream, with load/restart asserted during the reset cycle
    stream(0, "$GPZ", 0, 4'hF, 1'b0, 4'd0, 2'd0);
    rst[0] = 1'b1; ld[0] = 1'b1; rs[0] = 1'b1; dat[0] = "D";
    @(negedge clk);
    rst[0] = 1'b0; ld[0] = 1'b0; rs[0] = 1'b0;
    chk_alive("u0 alive after reset", al0, 4'hF);
    send(0, "D", 1'b0, 1'b0, 4'd0, 2'd0, 1'b1, 4'hF);
    send(0, "A", 1'b0, 1'b0, 4'd0, 2'd0, 1'b1, 4'hF);

    // Anchored
    send(1, "X", 1'b0, 1'b0, 4'd0, 2'd0, 1'b1, 4'h0);
    for (int i = 0; i < 6; i++) begin
      string s;
      s = "$GPZDA";
      send(1, s[i], 1'b0, 1'b0, 4'd0, 2'd0, 1'b1, 4'h0);
    end
    send(1, "$", 1'b1, 1'b0, 4'd0, 2'd0, 1'b0, 4'hF);
    send(1, "G", 1'b0, 1'b0, 4'd0, 2'd0, 1'b0, 4'hF);
    send(1, "P", 1'b0, 1'b0, 4'd0, 2'd0, 1'b0, 4'hF);
    send(1, "Z", 1'b0, 1'b0, 4'd0, 2'd0, 1'b0, 4'b0001);
    send(1, "D", 1'b0, 1'b0, 4'd0, 2'd0, 1'b0, 4'b0001);
    send(1, "A", 1'b0, 1'b1, 4'b0001, 2'd0, 1'b0, 4'b0000);

    // Wildcard, simultaneous completion
    stream(2, "$GPZDA", 0, 4'b0011, 1'b1, 4'b0011, 2'd0);

    idle(3);
    nvec++; if (q0.size() != 0) begin nfail++; $display("FAIL u0 drain: %0d left want 0", q0.size()); end
    nvec++; if (q1.size() != 0) begin nfail++; $display("FAIL u1 drain: %0d left want 0", q1.size()); end
    nvec++; if (q2.size() != 0) begin nfail++; $display("FAIL u2 drain: %0d left want 0", q2.size()); end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
